// File: rtl/rx_frame_bram_writer.sv
// MAC rx byte stream -> byte-enable BRAM port A writer with frame commit/hold
// handshake toward the AXI read side and a saturating drop counter.
module rx_frame_bram_writer #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1600,
    localparam int ADDR_W   = clogb2(RAM_DEPTH - 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [COL_WIDTH-1:0]        rx_data_i,
    input  logic                        rx_valid_i,
    input  logic                        rx_last_i,
    input  logic                        rx_err_i,
    output logic                        bram_en_o,
    output logic [NB_COL-1:0]           bram_we_o,
    output logic [ADDR_W-1:0]           bram_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0] bram_din_o,
    output logic                        frame_rdy_o,
    output logic [15:0]                 frame_len_o,
    input  logic                        frame_ack_i,
    output logic [15:0]                 drop_cnt_o
);

    function automatic int clogb2(input int depth);
        int d;
        d = depth;
        clogb2 = 0;
        while (d > 0) begin
            d = d >> 1;
            clogb2 = clogb2 + 1;
        end
    endfunction

    localparam int          LANE_W  = $clog2(NB_COL);
    localparam logic [15:0] MAX_CNT = 16'(NB_COL * RAM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DISCARD, S_COMMIT, S_HOLD} state_t;

    state_t                        state_q, state_d;
    logic [15:0]                   byte_cnt_q, byte_cnt_d;
    logic                          in_frame_q, in_frame_d;
    logic [15:0]                   frame_len_q, frame_len_d;
    logic [15:0]                   drop_cnt_q, drop_cnt_d;
    logic                          en_q, en_d;
    logic [NB_COL-1:0]             we_q, we_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [NB_COL*COL_WIDTH-1:0]   din_q, din_d;
    logic                          wr, drop, in_frame_nxt;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        in_frame_d   = in_frame_q;
        frame_len_d  = frame_len_q;
        wr           = 1'b0;
        drop         = 1'b0;
        in_frame_nxt = in_frame_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    wr         = 1'b1;
                    byte_cnt_d = 16'd1;
                    state_d    = S_FILL;
                    if (rx_last_i) begin
                        if (rx_err_i) begin
                            drop       = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            frame_len_d = 16'd1;
                            state_d     = S_COMMIT;
                        end
                    end
                end
            end
            S_FILL: begin
                if (rx_valid_i) begin
                    // buffer full: a further byte means the frame cannot fit
                    if (byte_cnt_q == MAX_CNT) begin
                        if (rx_last_i) begin
                            drop       = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else begin
                        wr         = 1'b1;
                        byte_cnt_d = byte_cnt_q + 16'd1;
                        if (rx_last_i) begin
                            if (rx_err_i) begin
                                drop       = 1'b1;
                                byte_cnt_d = '0;
                                state_d    = S_IDLE;
                            end else begin
                                frame_len_d = byte_cnt_q + 16'd1;
                                state_d     = S_COMMIT;
                            end
                        end
                    end
                end
            end
            S_DISCARD: begin
                if (rx_valid_i && rx_last_i) begin
                    drop       = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            S_COMMIT, S_HOLD: begin
                if (rx_valid_i) begin
                    drop         = rx_last_i;
                    in_frame_nxt = ~rx_last_i;
                end
                in_frame_d = in_frame_nxt;
                if (state_q == S_COMMIT) begin
                    state_d = S_HOLD;
                end else if (frame_ack_i) begin
                    // a frame still running after the ack must be skipped to its end
                    state_d    = in_frame_nxt ? S_DISCARD : S_IDLE;
                    byte_cnt_d = '0;
                    in_frame_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d       = wr;
        we_d       = wr ? (NB_COL'(1) << byte_cnt_q[LANE_W-1:0]) : '0;
        addr_d     = wr ? byte_cnt_q[LANE_W +: ADDR_W] : addr_q;
        din_d      = wr ? {NB_COL{rx_data_i}} : din_q;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            in_frame_q  <= 1'b0;
            frame_len_q <= '0;
            drop_cnt_q  <= '0;
            en_q        <= 1'b0;
            we_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            in_frame_q  <= in_frame_d;
            frame_len_q <= frame_len_d;
            drop_cnt_q  <= drop_cnt_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign bram_en_o   = en_q;
    assign bram_we_o   = we_q;
    assign bram_addr_o = addr_q;
    assign bram_din_o  = din_q;
    assign frame_rdy_o = (state_q == S_HOLD);
    assign frame_len_o = frame_len_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_bram_writer.sv
// Directed bench for rx_frame_bram_writer: BRAM write pattern, commit/ack,
// drops (error, oversize, arrival in HOLD) and mid-frame reset.
module tb_rx_frame_bram_writer;

    localparam int ADDR_W = 11;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_last_i = 1'b0;
    logic        rx_err_i = 1'b0;
    logic        bram_en_o;
    logic [3:0]  bram_we_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [31:0] bram_din_o;
    logic        frame_rdy_o;
    logic [15:0] frame_len_o;
    logic        frame_ack_i = 1'b0;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [3:0]        log_we[$];
    logic [31:0]       log_din[$];

    rx_frame_bram_writer dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .rx_last_i(rx_last_i), .rx_err_i(rx_err_i),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
        .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o),
        .frame_rdy_o(frame_rdy_o), .frame_len_o(frame_len_o),
        .frame_ack_i(frame_ack_i), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rstn_i && bram_en_o) begin
            log_addr.push_back(bram_addr_o);
            log_we.push_back(bram_we_o);
            log_din.push_back(bram_din_o);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_din.delete();
    endtask

    // Drives n bytes (data = index + seed); returns at the negedge after the last
    // byte has been sampled, with the rx inputs idle.
    task automatic send_frame(input int n, input bit err, input int ack_at,
                              input bit with_last, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rx_valid_i  = 1'b1;
            rx_data_i   = 8'(i) + seed;
            rx_last_i   = with_last && (i == n - 1);
            rx_err_i    = err && (i == n - 1);
            frame_ack_i = (i == ack_at);
        end
        @(negedge clk_i);
        rx_valid_i  = 1'b0;
        rx_last_i   = 1'b0;
        rx_err_i    = 1'b0;
        frame_ack_i = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk_i);
        frame_ack_i = 1'b1;
        @(negedge clk_i);
        frame_ack_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (bram_en_o !== 1'b0) begin errors++; $display("FAIL rst_en: got %0h want 0", bram_en_o); end
        checks++; if (bram_we_o !== 4'h0) begin errors++; $display("FAIL rst_we: got %0h want 0", bram_we_o); end
        checks++; if (bram_addr_o !== '0) begin errors++; $display("FAIL rst_addr: got %0h want 0", bram_addr_o); end
        checks++; if (bram_din_o !== 32'h0) begin errors++; $display("FAIL rst_din: got %0h want 0", bram_din_o); end
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %0h want 0", frame_rdy_o); end
        checks++; if (frame_len_o !== 16'h0) begin errors++; $display("FAIL rst_len: got %0h want 0", frame_len_o); end
        checks++; if (drop_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_drop: got %0h want 0", drop_cnt_o); end
        rstn_i = 1'b1;
    endtask

    task automatic test_good_64();
        int bad;
        logic [ADDR_W-1:0] ea;
        logic [3:0] ew;
        logic [7:0] eb;
        clear_log();
        send_frame(64, 1'b0, -1, 1'b1, 8'h00);
        #1;
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL g64_commit_rdy: got %0h want 0", frame_rdy_o); end
        checks++; if (bram_en_o !== 1'b1) begin errors++; $display("FAIL g64_commit_en: got %0h want 1", bram_en_o); end
        @(negedge clk_i); #1;
        checks++; if (frame_rdy_o !== 1'b1) begin errors++; $display("FAIL g64_rdy: got %0h want 1", frame_rdy_o); end
        checks++; if (frame_len_o !== 16'd64) begin errors++; $display("FAIL g64_len: got %0d want 64", frame_len_o); end
        checks++; if (bram_en_o !== 1'b0) begin errors++; $display("FAIL g64_hold_en: got %0h want 0", bram_en_o); end
        checks++; if (log_addr.size() !== 64) begin errors++; $display("FAIL g64_wcount: got %0d want 64", log_addr.size()); end
        bad = 0;
        for (int i = 0; i < 64 && i < log_addr.size(); i++) begin
            ea = ADDR_W'(i / 4);
            ew = 4'(1 << (i % 4));
            eb = 8'(i);
            if (log_addr[i] !== ea || log_we[i] !== ew || log_din[i] !== {4{eb}}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL g64_wseq: got %0d bad writes want 0", bad); end
        do_ack();
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL g64_ack: got %0h want 0", frame_rdy_o); end
    endtask

    task automatic test_small();
        clear_log();
        send_frame(1, 1'b0, -1, 1'b1, 8'hA5);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL s1_wcount: got %0d want 1", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== '0 || log_we[0] !== 4'b0001) begin errors++; $display("FAIL s1_write: got addr %0h we %0b want addr 0 we 0001", log_addr[0], log_we[0]); end
            checks++; if (log_din[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL s1_din: got %0h want a5a5a5a5", log_din[0]); end
        end
        checks++; if (frame_rdy_o !== 1'b1 || frame_len_o !== 16'd1) begin errors++; $display("FAIL s1_len: got rdy %0h len %0d want rdy 1 len 1", frame_rdy_o, frame_len_o); end
        do_ack();
        clear_log();
        send_frame(5, 1'b0, -1, 1'b1, 8'h10);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 5) begin errors++; $display("FAIL s5_wcount: got %0d want 5", log_addr.size()); end
        if (log_addr.size() == 5) begin
            checks++; if (log_addr[4] !== ADDR_W'(1) || log_we[4] !== 4'b0001) begin errors++; $display("FAIL s5_last: got addr %0h we %0b want addr 1 we 0001", log_addr[4], log_we[4]); end
        end
        checks++; if (frame_len_o !== 16'd5) begin errors++; $display("FAIL s5_len: got %0d want 5", frame_len_o); end
        do_ack();
    endtask

    task automatic test_err_drop();
        send_frame(100, 1'b1, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL err_rdy: got %0h want 0", frame_rdy_o); end
        checks++; if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL err_drop: got %0d want 1", drop_cnt_o); end
        clear_log();
        send_frame(8, 1'b0, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 8) begin errors++; $display("FAIL err_next_wcount: got %0d want 8", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== '0 || log_we[0] !== 4'b0001) begin errors++; $display("FAIL err_next_first: got addr %0h we %0b want addr 0 we 0001", log_addr[0], log_we[0]); end
        end
        checks++; if (frame_rdy_o !== 1'b1 || frame_len_o !== 16'd8) begin errors++; $display("FAIL err_next_len: got rdy %0h len %0d want rdy 1 len 8", frame_rdy_o, frame_len_o); end
        do_ack();
    endtask

    task automatic test_oversize();
        clear_log();
        send_frame(6401, 1'b0, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 6400) begin errors++; $display("FAIL ovr_wcount: got %0d want 6400", log_addr.size()); end
        if (log_addr.size() == 6400) begin
            checks++; if (log_addr[6399] !== ADDR_W'(1599) || log_we[6399] !== 4'b1000) begin errors++; $display("FAIL ovr_last: got addr %0d we %0b want addr 1599 we 1000", log_addr[6399], log_we[6399]); end
        end
        checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovr_drop: got %0d want 2", drop_cnt_o); end
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL ovr_rdy: got %0h want 0", frame_rdy_o); end
    endtask

    task automatic test_hold_arrival();
        send_frame(20, 1'b0, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (frame_rdy_o !== 1'b1 || frame_len_o !== 16'd20) begin errors++; $display("FAIL hold_commit: got rdy %0h len %0d want rdy 1 len 20", frame_rdy_o, frame_len_o); end
        clear_log();
        send_frame(60, 1'b0, 9, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL hold_nowrite: got %0d writes want 0", log_addr.size()); end
        checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL hold_drop: got %0d want 3", drop_cnt_o); end
        checks++; if (frame_rdy_o !== 1'b0) begin errors++; $display("FAIL hold_rdy: got %0h want 0", frame_rdy_o); end
        checks++; if (frame_len_o !== 16'd20) begin errors++; $display("FAIL hold_len_kept: got %0d want 20", frame_len_o); end
        clear_log();
        send_frame(12, 1'b0, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 12) begin errors++; $display("FAIL hold_third_wcount: got %0d want 12", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== '0 || log_we[0] !== 4'b0001) begin errors++; $display("FAIL hold_third_first: got addr %0h we %0b want addr 0 we 0001", log_addr[0], log_we[0]); end
        end
        checks++; if (frame_len_o !== 16'd12) begin errors++; $display("FAIL hold_third_len: got %0d want 12", frame_len_o); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        send_frame(20, 1'b0, -1, 1'b0, 8'h00);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        checks++; if (bram_en_o !== 1'b0 || bram_we_o !== 4'h0) begin errors++; $display("FAIL rmid_wr: got en %0h we %0h want 0 0", bram_en_o, bram_we_o); end
        checks++; if (bram_addr_o !== '0 || bram_din_o !== 32'h0) begin errors++; $display("FAIL rmid_bus: got addr %0h din %0h want 0 0", bram_addr_o, bram_din_o); end
        checks++; if (frame_rdy_o !== 1'b0 || frame_len_o !== 16'h0) begin errors++; $display("FAIL rmid_frame: got rdy %0h len %0d want 0 0", frame_rdy_o, frame_len_o); end
        checks++; if (drop_cnt_o !== 16'h0) begin errors++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt_o); end
        clear_log();
        send_frame(4, 1'b0, -1, 1'b1, 8'h00);
        @(negedge clk_i); #1;
        checks++; if (log_addr.size() !== 4) begin errors++; $display("FAIL rmid_next_wcount: got %0d want 4", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== '0 || log_we[0] !== 4'b0001) begin errors++; $display("FAIL rmid_next_first: got addr %0h we %0b want addr 0 we 0001", log_addr[0], log_we[0]); end
        end
        checks++; if (frame_rdy_o !== 1'b1 || frame_len_o !== 16'd4) begin errors++; $display("FAIL rmid_next_len: got rdy %0h len %0d want rdy 1 len 4", frame_rdy_o, frame_len_o); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_good_64();
        test_small();
        test_err_drop();
        test_oversize();
        test_hold_arrival();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
